// File: rtl/pipe_stall_flush_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stall_flush_ctrl: F/D enable and ID/EX flush generation, MDU busy   |
// | sequencing and stall/redirect arbitration for the 5-stage pipeline.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stall_flush_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_data_stall,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        req,
  input  logic        M_isEret,
  output logic        F_pc_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             stall;
  logic             redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_done     = 1'b0;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        // A start coinciding with req belongs to an instruction being flushed.
        if (E_md_start && !req) begin
          cnt_d   = E_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          md_done = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    md_busy  = E_md_start | (state_q == BUSY);
    stall    = D_data_stall | (D_is_md & md_busy);
    redirect = req | M_isEret;

    // Exception entry and eret must keep F/D loading, so they beat stall.
    F_pc_en = redirect | ~stall;
    D_en    = redirect | ~stall;
    E_flush = redirect | stall;

    if (stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_stall_flush_ctrl.md
Name: pipe_stall_flush_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Generates the enable for the PC and the IF/ID register, and the flush for ID/EX.
- Sequences the multi-cycle mult/div unit (busy counter) and arbitrates stall against exception entry (req) and eret redirect.
- Sits between the decoder hazard logic, CP0 and the pipeline registers; it is the only source of F/D enables.

Parameters:
- MULT_CYCLES, 5, E-stage busy cycles for mult/multu.
- DIV_CYCLES, 10, E-stage busy cycles for div/divu.
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- D_data_stall  input  1  decoder data-hazard stall request (Tuse/Tnew mismatch), combinational.
- D_is_md  input  1  instruction in D uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_md_start  input  1  instruction in E is mult/multu/div/divu and valid.
- E_md_is_div  input  1  1 = div/divu, 0 = mult/multu; qualified by E_md_start.
- req  input  1  CP0 exception/interrupt request (M stage).
- M_isEret  input  1  eret in M stage.
- F_pc_en  output  1  PC register enable.
- D_en  output  1  IF/ID enable.
- E_flush  output  1  clear ID/EX (insert bubble).
- md_busy  output  1  MDU busy (start or counter nonzero).
- md_done  output  1  one-cycle pulse on the last busy cycle.
- stall_cnt  output  32  saturating count of stall cycles.

Behaviour:
- State: IDLE, BUSY. Counter cnt[CNT_W-1:0].
- Reset: state=IDLE, cnt=0, stall_cnt=0.
- Reset outputs: F_pc_en=1, D_en=1, E_flush=0, md_busy=0, md_done=0.

MDU sequencing:
- IDLE & E_md_start & !req: load cnt = E_md_is_div ? DIV_CYCLES : MULT_CYCLES; go to BUSY.
- BUSY: cnt decrements every cycle. When cnt==1, md_done=1 (combinational) and the next state is IDLE with cnt=0.
- md_busy = E_md_start | (state==BUSY). Combinational, so the start cycle already blocks D.
- E_md_start while BUSY: ignored. It cannot legally occur, because D stalls on D_is_md.
- req does not abort a BUSY operation: HI/LO still complete. An E_md_start in the same cycle as req is discarded; that E instruction is being flushed.

Stall:
- stall = D_data_stall | (D_is_md & md_busy).
- Normal case: F_pc_en = !stall, D_en = !stall, E_flush = stall.

Priority:
- req > M_isEret > stall.
- req=1 or M_isEret=1: F_pc_en=1, D_en=1, E_flush=1. Both forcibly override stall: the IF/ID register takes its own req/eret load, and the pipeline must not freeze.

stall_cnt:
- Increments when stall & !req & !M_isEret.
- Saturates at 32'hFFFF_FFFF (no wrap).

Reset mid-operation: reset while BUSY returns to IDLE, cnt=0 on the next edge. md_done is not asserted.

Latency: counter load to md_done is exactly N cycles after the start cycle (start cycle + N BUSY cycles, done on the last one).

Test Plan:
- Reset, then all inputs 0 -> F_pc_en=1, D_en=1, E_flush=0, md_busy=0, stall_cnt=0.
- E_md_start=1, E_md_is_div=0 for one cycle, D_is_md=1 held -> md_busy high for 6 cycles (start + 5). md_done high only on cycle 6. D_en=0 and E_flush=1 during those 6 cycles. stall_cnt=6.
- Div start -> md_busy for 11 cycles, md_done on cycle 11, with D_is_md=0 -> D_en stays 1 throughout.
- Mult start, then req=1 on BUSY cycle 3 while D_is_md=1 -> that cycle gives D_en=1, F_pc_en=1, E_flush=1. md_done still on cycle 6. stall_cnt does not count the req cycle.
- req=1 with E_md_start=1 in IDLE -> state stays IDLE, md_busy=1 only that cycle (combinational), no md_done.
- D_data_stall=1 with M_isEret=1 -> D_en=1, E_flush=1. After 2^32 stall cycles (force stall_cnt to FFFF_FFFE) -> saturates at FFFF_FFFF.
- Reset asserted on BUSY cycle 4 of a div -> next cycle md_busy=0, md_done never pulses.
